// File: rtl/led_shift_arbiter_if.sv
// Requester-side handshake bundle for led_shift_arbiter: two request/data/ack channels.
interface led_shift_arbiter_if #(
  parameter int unsigned FRAME_W = 16
);
  logic               req_a;
  logic [FRAME_W-1:0] data_a;
  logic               ack_a;
  logic               req_b;
  logic [FRAME_W-1:0] data_b;
  logic               ack_b;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b
  );
endinterface

// File: rtl/led_shift_arbiter.sv
// Round-robin two-requester arbiter feeding an MSB-first LED shift/latch serializer.
// Optional periodic re-send of the last frame is enabled by LED_SHIFT_AUTO_REFRESH_EN.
module led_shift_arbiter #(
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned DIV         = 4,
  parameter int unsigned REFRESH_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  led_shift_arbiter_if.slave      req_if,
  output logic                    ser_clk,
  output logic                    ser_do,
  output logic                    ser_clr,
  output logic                    busy,
  output logic                    done,
  output logic                    last_grant
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);

  // Reject parameter sets the bit timing cannot realise.
  if (DIV < 2 || (DIV % 2) != 0 || FRAME_W < 2 || REFRESH_CYC < 2) begin : g_bad_param
    $error("led_shift_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_cnt, div_d;
  logic [BIT_W-1:0]   bit_cnt, bit_d;
  logic [FRAME_W-1:0] shreg, shreg_d;
  logic               ser_clk_d, ser_do_d, busy_d, done_d, last_grant_d;
  logic               ack_a_d, ack_b_d;
  logic               start;
  logic [FRAME_W-1:0] start_frame;
  logic               grant_b;

`ifdef LED_SHIFT_AUTO_REFRESH_EN
  localparam int unsigned REF_W = $clog2(REFRESH_CYC);
  logic [REF_W-1:0]   ref_cnt, ref_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
`endif

  assign ser_clr = 1'b1;

  // B wins only when A is absent or A was served last.
  assign grant_b = req_if.req_b & (~req_if.req_a | ~last_grant);

  always_comb begin
    state_d      = state;
    div_d        = div_cnt;
    bit_d        = bit_cnt;
    shreg_d      = shreg;
    ser_clk_d    = ser_clk;
    ser_do_d     = ser_do;
    busy_d       = busy;
    done_d       = 1'b0;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    last_grant_d = last_grant;
    start        = 1'b0;
    start_frame  = '0;

    case (state)
      IDLE: begin
        ser_clk_d = 1'b1;
        ser_do_d  = 1'b1;
        busy_d    = 1'b0;
        if (req_if.req_a || req_if.req_b) begin
          start = 1'b1;
          if (grant_b) begin
            ack_b_d      = 1'b1;
            last_grant_d = 1'b1;
            start_frame  = req_if.data_b;
          end else begin
            ack_a_d      = 1'b1;
            last_grant_d = 1'b0;
            start_frame  = req_if.data_a;
          end
        end
`ifdef LED_SHIFT_AUTO_REFRESH_EN
        else if (ref_cnt == REF_W'(REFRESH_CYC - 1)) begin
          start       = 1'b1;
          start_frame = frame_q;
        end
`endif
        if (start) begin
          state_d   = SHIFT;
          div_d     = '0;
          bit_d     = BIT_W'(FRAME_W);
          shreg_d   = start_frame;
          ser_clk_d = 1'b0;
          ser_do_d  = ~start_frame[FRAME_W-1];
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt != DIV_W'(DIV - 1)) begin
          div_d     = div_cnt + DIV_W'(1);
          ser_clk_d = (div_d >= DIV_W'(DIV / 2));
        end else begin
          div_d = '0;
          if (bit_cnt == BIT_W'(1)) begin
            state_d   = LATCH;
            ser_clk_d = 1'b1;
            ser_do_d  = 1'b1;
          end else begin
            bit_d     = bit_cnt - BIT_W'(1);
            shreg_d   = shreg << 1;
            ser_clk_d = 1'b0;
            ser_do_d  = ~shreg_d[FRAME_W-1];
          end
        end
      end

      LATCH: begin
        if (div_cnt != DIV_W'(DIV - 1)) begin
          div_d = div_cnt + DIV_W'(1);
        end else begin
          div_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef LED_SHIFT_AUTO_REFRESH_EN
  // Idle timer and last-sent frame for the automatic re-send.
  always_comb begin
    ref_d   = ref_cnt;
    frame_d = frame_q;
    if (start) begin
      ref_d   = '0;
      frame_d = start_frame;
    end else if (state == IDLE) begin
      ref_d = ref_cnt + REF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      frame_q <= '0;
    end else begin
      ref_cnt <= ref_d;
      frame_q <= frame_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      ser_clk      <= 1'b1;
      ser_do       <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      req_if.ack_a <= 1'b0;
      req_if.ack_b <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      state        <= state_d;
      div_cnt      <= div_d;
      bit_cnt      <= bit_d;
      shreg        <= shreg_d;
      ser_clk      <= ser_clk_d;
      ser_do       <= ser_do_d;
      busy         <= busy_d;
      done         <= done_d;
      req_if.ack_a <= ack_a_d;
      req_if.ack_b <= ack_b_d;
      last_grant   <= last_grant_d;
    end
  end

endmodule

// File: doc/led_shift_arbiter.md
LED_SHIFT_ARBITER -- requirements
Module: led_shift_arbiter

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 16, meaning the bits per frame, which are shifted MSB first.
REQ-002 The block SHALL have parameter DIV, default 4, meaning system clocks per serial bit; it must be even and at least 2.
REQ-003 The block SHALL have parameter REFRESH_CYC, default 1000000, meaning the idle clocks before an automatic re-send.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: `clk  in  1  system clock, rising edge`; `rst_n  in  1  asynchronous active-low reset`.
REQ-005 The block SHALL have the requester ports `req_a  in  1  frame request A`, `data_a  in  FRAME_W  frame A`, `ack_a  out  1  one-cycle accept pulse A`.
REQ-006 The block SHALL have the requester ports `req_b  in  1  frame request B`, `data_b  in  FRAME_W  frame B`, `ack_b  out  1  one-cycle accept pulse B`.
REQ-007 The block SHALL have the serial ports `ser_clk  out  1  shift clock, idle high`, `ser_do  out  1  inverted serial data (LED active-low)`, `ser_clr  out  1  constant 1`.
REQ-008 The block SHALL have the status ports `busy  out  1  frame in progress`, `done  out  1  one-cycle pulse at frame end`, `last_grant  out  1  0=A, 1=B, last requester served`.

Function
REQ-009 The block SHALL implement the states IDLE, SHIFT and LATCH only.
REQ-010 IDLE SHALL sample req_a/req_b each edge; any request high moves the block to SHIFT on that edge, captures the granted data_x, and raises ack_x for exactly the next cycle.
REQ-011 Arbitration SHALL be round-robin: when both requests are high, the grant goes to the requester not equal to last_grant; last_grant then updates to the winner.
REQ-012 Requests arriving while busy SHALL NOT be acknowledged; the requester holds req_x and data_x until ack_x, and a second grant is issued no earlier than the return to IDLE.
REQ-013 SHIFT SHALL output the frame MSB first, one bit per DIV clocks.
REQ-014 Within each bit of SHIFT, ser_clk SHALL be low for the first DIV/2 clocks and high for the last DIV/2, and ser_do SHALL equal the inverted bit for all DIV clocks.
REQ-015 The first bit SHALL appear on ser_do in the cycle after acceptance, with ser_clk low.
REQ-016 After FRAME_W bits, LATCH SHALL hold ser_clk high and ser_do=1 for DIV clocks, then pulse done for one cycle while entering IDLE.
REQ-017 busy SHALL be high from the cycle after acceptance through the last LATCH cycle, i.e. exactly (FRAME_W+1)*DIV cycles.
REQ-018 In IDLE, ser_clk=1, ser_do=1, ack_a=0, ack_b=0, busy=0.
REQ-019 A request in IDLE SHALL start a new frame with no dead cycle after done.
REQ-020 The bit counter SHALL count FRAME_W down to 1, with no wrap beyond FRAME_W bits.
REQ-021 Requests during reset SHALL be ignored; the first edge after rst_n rises may accept.

Reset
REQ-022 While rst_n=0, asynchronously: state=IDLE, ser_clk=1, ser_do=1, ser_clr=1, ack_a=0, ack_b=0, busy=0, done=0, last_grant=1 (so A wins the first tie), stored frame=0, refresh counter=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no done or ack is produced for the aborted frame.

Configuration
REQ-024 The macro LED_SHIFT_AUTO_REFRESH_EN SHALL control automatic re-send of the last transmitted frame.
REQ-025 When LED_SHIFT_AUTO_REFRESH_EN is defined, an idle counter SHALL increment each IDLE cycle and clear on every frame start.
REQ-026 When LED_SHIFT_AUTO_REFRESH_EN is defined and the counter reaches REFRESH_CYC-1 with no request, the stored frame SHALL be re-sent with no ack, with last_grant unchanged, and with identical timing.
REQ-027 When LED_SHIFT_AUTO_REFRESH_EN is defined, a request on the same edge as refresh expiry SHALL win.
REQ-028 When LED_SHIFT_AUTO_REFRESH_EN is undefined, the counter and stored-frame re-send logic SHALL be absent, and the block stays in IDLE until a request arrives.

Verification
REQ-029 Single request: DIV=4, req_a with data_a=16'hA5C3 -> ack_a is one cycle; ser_do over 16 bits is ~A5C3 MSB first; busy is high for 68 cycles; done pulses once.
REQ-030 Tie after reset: req_a=req_b=1, data_a=16'h0001, data_b=16'h8000 -> A is served first, then B back-to-back with no gap after done; last_grant ends at 1.
REQ-031 Busy blocking: raise req_b 10 cycles into frame A -> ack_b is asserted only in the cycle after done; B's frame starts immediately.
REQ-032 Mid-frame reset: assert rst_n=0 at bit 7 -> ser_clk=1 and ser_do=1 in the same cycle; no done pulse; a later req_a restarts from the MSB.
REQ-033 Refresh with LED_SHIFT_AUTO_REFRESH_EN, REFRESH_CYC=50: send 16'h00FF, then idle -> an identical frame starts 50 IDLE cycles after done, with no ack.
REQ-034 Refresh collision with LED_SHIFT_AUTO_REFRESH_EN: req_b rises on the expiry edge -> data_b is sent with ack_b; refresh is deferred and the counter cleared.
